// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with pending scoreboard, write bypass and clear engine
module regfile_sb #(
   parameter int NUM_ADDR_BITS = 6,
   parameter int REG_WIDTH     = 32,
   parameter int NUM_RD_PORTS  = 3,
   parameter int NUM_WR_PORTS  = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_WR_PORTS-1:0]               wrEnable,
   input  logic [NUM_WR_PORTS*NUM_ADDR_BITS-1:0] wrAddr,
   input  logic [NUM_WR_PORTS*REG_WIDTH-1:0]     wrData,
   input  logic [NUM_RD_PORTS*NUM_ADDR_BITS-1:0] rdAddr,
   output logic [NUM_RD_PORTS*REG_WIDTH-1:0]     rdData,
   output logic [NUM_RD_PORTS-1:0]               rdPending,
   input  logic                                  rsvEnable,
   input  logic [NUM_ADDR_BITS-1:0]              rsvAddr,
   output logic                                  initBusy,
   output logic                                  wrCollision
);

   localparam int NUM_REGS = 2**NUM_ADDR_BITS;
   localparam logic [NUM_ADDR_BITS-1:0] LAST_IDX = '1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                     state_q, state_d;
   logic [NUM_ADDR_BITS-1:0]   cnt_q, cnt_d;
   logic [NUM_REGS-1:0]        pend_q, pend_d;
   logic                       coll_q, coll_d;
   logic [REG_WIDTH-1:0]       regs_q [NUM_REGS];

   logic                       run;
   logic [NUM_ADDR_BITS-1:0]   wr_addr [NUM_WR_PORTS];
   logic [REG_WIDTH-1:0]       wr_data [NUM_WR_PORTS];
   logic [NUM_ADDR_BITS-1:0]   rd_addr [NUM_RD_PORTS];
   logic [NUM_WR_PORTS-1:0]    wr_en;

   assign run         = (state_q == ST_RUN);
   assign initBusy    = ~run;
   assign wrCollision = coll_q;

   for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_wr
      assign wr_addr[p] = wrAddr[p*NUM_ADDR_BITS +: NUM_ADDR_BITS];
      assign wr_data[p] = wrData[p*REG_WIDTH +: REG_WIDTH];
      // Writes to r0 are dropped here so they never bypass, clear pending or collide.
      assign wr_en[p]   = run && wrEnable[p] && (wr_addr[p] != '0);
   end

   for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd
      assign rd_addr[r] = rdAddr[r*NUM_ADDR_BITS +: NUM_ADDR_BITS];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         if (cnt_q == LAST_IDX) state_d = ST_RUN;
         else                   cnt_d   = cnt_q + 1'b1;
      end
   end

   always_comb begin
      coll_d = coll_q;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
         for (int q = p + 1; q < NUM_WR_PORTS; q++) begin
            if (wr_en[p] && wr_en[q] && (wr_addr[p] == wr_addr[q])) coll_d = 1'b1;
         end
      end
   end

   // Reservation is applied after write clears so a new producer keeps the bit set.
   always_comb begin
      pend_d = pend_q;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
         if (wr_en[p]) pend_d[wr_addr[p]] = 1'b0;
      end
      if (run && rsvEnable) pend_d[rsvAddr] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= NUM_ADDR_BITS'(1);
         pend_q  <= '0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         coll_q  <= coll_d;
      end
   end

   // Storage has no reset; the clear engine zeroes it while in INIT.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         regs_q[cnt_q] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wr_en[p]) regs_q[wr_addr[p]] <= wr_data[p];
         end
      end
   end

   logic [REG_WIDTH-1:0] rd_val [NUM_RD_PORTS];
   logic [NUM_RD_PORTS-1:0] rd_hit;

   always_comb begin
      rdData    = '0;
      rdPending = '0;
      rd_hit    = '0;
      for (int r = 0; r < NUM_RD_PORTS; r++) begin
         rd_val[r] = '0;
         if (run && (rd_addr[r] != '0)) begin
            rd_val[r] = regs_q[rd_addr[r]];
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
               if (wr_en[p] && (wr_addr[p] == rd_addr[r])) begin
                  rd_hit[r] = 1'b1;
                  rd_val[r] = wr_data[p];
               end
            end
            rdPending[r] = pend_q[rd_addr[r]] & ~rd_hit[r];
         end
         rdData[r*REG_WIDTH +: REG_WIDTH] = rd_val[r];
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  wrEnable;
   logic [11:0] wrAddr;
   logic [63:0] wrData;
   logic [17:0] rdAddr;
   logic [95:0] rdData;
   logic [2:0]  rdPending;
   logic        rsvEnable;
   logic [5:0]  rsvAddr;
   logic        initBusy;
   logic        wrCollision;

   int n_vec = 0;
   int n_err = 0;
   int n_cyc;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk(clk), .rst_n(rst_n),
      .wrEnable(wrEnable), .wrAddr(wrAddr), .wrData(wrData),
      .rdAddr(rdAddr), .rdData(rdData), .rdPending(rdPending),
      .rsvEnable(rsvEnable), .rsvAddr(rsvAddr),
      .initBusy(initBusy), .wrCollision(wrCollision)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_wr(input int p, input logic en, input logic [5:0] a, input logic [31:0] d);
      wrEnable[p]        = en;
      wrAddr[p*6 +: 6]   = a;
      wrData[p*32 +: 32] = d;
   endtask

   task automatic set_rd(input int r, input logic [5:0] a);
      rdAddr[r*6 +: 6] = a;
   endtask

   function automatic logic [31:0] rd(input int r);
      return rdData[r*32 +: 32];
   endfunction

   // Steps from the current negedge; returns posedges until initBusy falls.
   task automatic count_init(output int n);
      n = 0;
      while (initBusy && n < 200) begin
         @(posedge clk);
         n++;
         #1;
      end
   endtask

   task automatic idle;
      wrEnable  = '0;
      rsvEnable = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wrEnable = '0; wrAddr = '0; wrData = '0;
      rdAddr = '0; rsvEnable = 1'b0; rsvAddr = '0;

      // reset state
      @(negedge clk); set_rd(0, 6'd5); #1;
      chk("rst_initBusy",    {31'd0, initBusy}, 32'd1);
      chk("rst_rdData0",     rd(0), 32'd0);
      chk("rst_rdPending",   {29'd0, rdPending}, 32'd0);
      chk("rst_wrCollision", {31'd0, wrCollision}, 32'd0);

      @(negedge clk); rst_n = 1'b1;
      count_init(n_cyc);
      chk("init_len", n_cyc, 32'd63);
      idle();
      @(negedge clk);
      for (int a = 0; a < 64; a++) begin
         set_rd(a % 3, a[5:0]); #1;
         chk($sformatf("clear_r%0d", a), rd(a % 3), 32'd0);
      end

      // bypass then storage read of r5
      @(negedge clk); set_wr(0, 1'b1, 6'd5, 32'h12345678); set_rd(0, 6'd5); #1;
      chk("byp_r5", rd(0), 32'h12345678);
      chk("byp_r5_pend", {31'd0, rdPending[0]}, 32'd0);
      @(negedge clk); idle(); #1;
      chk("store_r5", rd(0), 32'h12345678);

      // r0 is immutable and never pending or colliding
      @(negedge clk);
      set_wr(0, 1'b1, 6'd0, 32'hDEADBEEF); set_wr(1, 1'b1, 6'd0, 32'hDEADBEEF);
      rsvEnable = 1'b1; rsvAddr = 6'd0; set_rd(2, 6'd0); #1;
      chk("r0_byp", rd(2), 32'd0);
      @(negedge clk); idle(); #1;
      chk("r0_read", rd(2), 32'd0);
      chk("r0_pend", {31'd0, rdPending[2]}, 32'd0);
      chk("r0_coll", {31'd0, wrCollision}, 32'd0);

      // reservation of r7
      @(negedge clk); rsvEnable = 1'b1; rsvAddr = 6'd7; set_rd(1, 6'd7); #1;
      chk("rsv_same_cyc", {31'd0, rdPending[1]}, 32'd0);
      @(negedge clk); idle(); #1;
      chk("rsv_next_cyc", {31'd0, rdPending[1]}, 32'd1);
      @(negedge clk); set_wr(1, 1'b1, 6'd7, 32'h55); #1;
      chk("rsv_wr_pend", {31'd0, rdPending[1]}, 32'd0);
      chk("rsv_wr_data", rd(1), 32'h55);
      @(negedge clk); idle(); #1;
      chk("rsv_cleared", {31'd0, rdPending[1]}, 32'd0);
      @(negedge clk); set_wr(0, 1'b1, 6'd7, 32'h66); rsvEnable = 1'b1; rsvAddr = 6'd7; #1;
      chk("rsvwr_byp_pend", {31'd0, rdPending[1]}, 32'd0);
      @(negedge clk); idle(); #1;
      chk("rsvwr_pend", {31'd0, rdPending[1]}, 32'd1);
      chk("rsvwr_data", rd(1), 32'h66);

      // dual write to r9: port 1 wins, collision is sticky
      @(negedge clk);
      set_wr(0, 1'b1, 6'd9, 32'hAAAA0000); set_wr(1, 1'b1, 6'd9, 32'h0000BBBB); set_rd(1, 6'd9); #1;
      chk("coll_byp", rd(1), 32'h0000BBBB);
      chk("coll_not_yet", {31'd0, wrCollision}, 32'd0);
      @(negedge clk); idle(); #1;
      chk("coll_store", rd(1), 32'h0000BBBB);
      chk("coll_set", {31'd0, wrCollision}, 32'd1);
      repeat (3) @(negedge clk);
      #1 chk("coll_sticky", {31'd0, wrCollision}, 32'd1);

      // fill everything with all-ones before re-running INIT
      for (int a = 1; a < 64; a += 2) begin
         @(negedge clk);
         set_wr(0, 1'b1, 6'(a), 32'hFFFFFFFF); set_wr(1, 1'b1, 6'(a + 1), 32'hFFFFFFFF);
      end
      @(negedge clk); idle(); set_rd(0, 6'd2); set_rd(1, 6'd63); #1;
      chk("fill_r2", rd(0), 32'hFFFFFFFF);
      chk("fill_r63", rd(1), 32'hFFFFFFFF);

      // reset, then abort INIT at counter 30 and restart it
      rst_n = 1'b0; #1;
      chk("rst2_coll", {31'd0, wrCollision}, 32'd0);
      chk("rst2_rd", rd(0), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (29) @(posedge clk);
      @(negedge clk); rst_n = 1'b0; #1;
      chk("midinit_busy", {31'd0, initBusy}, 32'd1);
      @(negedge clk);
      set_wr(0, 1'b1, 6'd2, 32'hCAFE0000); set_wr(1, 1'b1, 6'd40, 32'hCAFE0001);
      rsvEnable = 1'b1; rsvAddr = 6'd4;
      rst_n = 1'b1; set_rd(0, 6'd2); #1;
      chk("init_rd_blocked", rd(0), 32'd0);
      count_init(n_cyc);
      idle();
      chk("reinit_len", n_cyc, 32'd63);
      @(negedge clk);
      for (int a = 0; a < 64; a++) begin
         set_rd(a % 3, a[5:0]); #1;
         chk($sformatf("reclear_r%0d", a), rd(a % 3), 32'd0);
         chk($sformatf("repend_r%0d", a), {31'd0, rdPending[a % 3]}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with scoreboard and write-through bypass, successor to the three-read/one-write CPU_NN register file. It provides NUM_RD_PORTS combinational read ports and NUM_WR_PORTS posedge write ports, with a hard-wired zero register. A per-register pending bit tracks outstanding writes for hazard checks. A sequential clear engine zeroes the array after reset, so the storage carries no reset and can map to distributed RAM.

## Interface
- NUM_ADDR_BITS, 6, address width; NUM_REGS = 2**NUM_ADDR_BITS
- REG_WIDTH, 32, data width
- NUM_RD_PORTS, 3, read port count (≥1)
- NUM_WR_PORTS, 2, write port count (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wrEnable  in  NUM_WR_PORTS  per-port write enable
- wrAddr  in  NUM_WR_PORTS*NUM_ADDR_BITS  write addresses, port p at slice p
- wrData  in  NUM_WR_PORTS*REG_WIDTH  write data, port p at slice p
- rdAddr  in  NUM_RD_PORTS*NUM_ADDR_BITS  read addresses
- rdData  out  NUM_RD_PORTS*REG_WIDTH  read data, combinational
- rdPending  out  NUM_RD_PORTS  1 = addressed register has an outstanding reservation
- rsvEnable  in  1  reserve (mark pending) rsvAddr
- rsvAddr  in  NUM_ADDR_BITS  register to reserve
- initBusy  out  1  clear engine active; writes and reservations ignored
- wrCollision  out  1  sticky: two enabled write ports hit the same nonzero address in one cycle

## Operation
- Reset (rst_n=0, asynchronous): FSM → INIT, clear counter → 1, all pending bits → 0, wrCollision → 0. Outputs during reset: initBusy=1, rdData=0, rdPending=0.
- FSM states:
  - INIT: each posedge writes 0 to register[counter] and increments the counter. When counter == NUM_REGS-1 is cleared, go to RUN.
  - RUN: normal operation, held until the next reset.
- INIT behaviour:
  - wrEnable and rsvEnable are ignored.
  - All rdData read 0 and all rdPending read 0.
- Register 0:
  - Reads always return 0.
  - Writes to it are dropped.
  - Reservations of it are dropped.
  - It never reads pending and never sets wrCollision.
- Write (RUN): at posedge each enabled port p writes wrData[p] to wrAddr[p].
  - If several ports target the same address, the highest-index port wins.
  - Any write clears the target's pending bit.
- Read bypass (RUN): rdData[r] is selected in this order:
  - 0 if rdAddr[r]==0;
  - else the winning same-cycle wrData if any enabled port targets rdAddr[r];
  - else the stored value.
- Reservation (RUN): rsvEnable sets pending[rsvAddr] at posedge.
  - A write and a reservation to the same address in the same cycle leave the bit set; the reservation wins because it marks a new producer.
- rdPending[r]: equals pending[rdAddr[r]] from the registered state, forced to 0 when a same-cycle write targets rdAddr[r] (data is being bypassed).
  - A same-cycle reservation is not visible until the next cycle.
- wrCollision: set at posedge in RUN when two or more enabled ports share a nonzero address. It stays set until reset.

## Timing
- Read latency 0 (combinational from rdAddr, wrEnable, wrAddr, wrData). Write latency 1: visible through storage from the cycle after the posedge, and through bypass in the same cycle.
- INIT length is NUM_REGS-1 posedges after rst_n rises (63 at default).
  - initBusy falls after the posedge that clears register NUM_REGS-1.
  - The first accepted write is on the following posedge.
- rst_n asserted mid-INIT or mid-RUN restarts INIT from counter 1.
  - Array contents are not guaranteed until INIT completes.
  - A write coincident with reset assertion is lost.
- Counter wraps nowhere: it saturates on the INIT→RUN transition.

## Test plan
- Reset release, default params:
  - initBusy=1 for exactly 63 posedges, then 0.
  - Every rdAddr reads 0x00000000 after completion, even if registers held 0xFFFFFFFF before reset.
- Port 0 writes 0x12345678 to r5; same cycle rdAddr[0]=5:
  - rdData[0]=0x12345678 combinationally (bypass).
  - The next cycle, with wrEnable=0, still reads 0x12345678.
- Ports 0 and 1 both write r9 (0xAAAA0000 and 0x0000BBBB) in one cycle:
  - r9 reads 0x0000BBBB.
  - wrCollision=1 and stays 1 until rst_n is pulsed.
- Reserve r7:
  - Next cycle rdPending=1 on a port reading r7.
  - A write of 0x55 to r7 drops rdPending to 0 in the same cycle and returns 0x55.
  - Simultaneous reserve plus write on r7 leaves rdPending=1 next cycle.
- Write 0xDEADBEEF to r0 and reserve r0:
  - r0 reads 0 with rdPending=0.
  - wrCollision stays 0 even when both write ports target r0.
- Assert rst_n mid-INIT (at counter 30), release:
  - Full 63-cycle INIT repeats.
  - Writes presented during INIT have no effect.
